// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the time-shared alu controller:
// alu control codes, controller state encoding and code validation.
package alu_share_ctrl_pkg;

   localparam int unsigned MIPS_DATAWIDTH = 32;

   localparam logic [5:0] ALU_AND = 6'b000000;
   localparam logic [5:0] ALU_OR  = 6'b000001;
   localparam logic [5:0] ALU_ADD = 6'b000010;
   localparam logic [5:0] ALU_SUB = 6'b100010;
   localparam logic [5:0] ALU_SLT = 6'b000011;
   localparam logic [5:0] ALU_XOR = 6'b000100;
   localparam logic [5:0] ALU_NOR = 6'b000101;
   localparam logic [5:0] ALU_LUI = 6'b000110;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} aluctl_state_t;

   function automatic logic alucont_valid(input logic [5:0] code);
      case (code)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
         ALU_SLT, ALU_XOR, ALU_NOR, ALU_LUI: alucont_valid = 1'b1;
         default:                            alucont_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the requesters (master) and the
// alu sharing controller (slave).
interface alu_share_ctrl_if
   import alu_share_ctrl_pkg::*;
#(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned DATAWIDTH = MIPS_DATAWIDTH
);
   logic [NREQ-1:0]                req_valid;
   logic [NREQ-1:0]                req_ready;
   logic [NREQ-1:0][DATAWIDTH-1:0] req_a;
   logic [NREQ-1:0][DATAWIDTH-1:0] req_b;
   logic [NREQ-1:0][5:0]           req_alucont;
   logic [NREQ-1:0]                resp_valid;
   logic [NREQ-1:0]                resp_ready;
   logic [DATAWIDTH-1:0]           resp_result;
   logic                           resp_overflow;
   logic                           resp_err;

   modport master (
      output req_valid, req_a, req_b, req_alucont, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_overflow, resp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_alucont, resp_ready,
      output req_ready, resp_valid, resp_result, resp_overflow, resp_err
   );
endinterface

// File: rtl/alu.sv
// Combinational MIPS-style alu: logic ops, wrapping add/sub with signed
// overflow, signed set-less-than and load-upper-immediate.
module alu
   import alu_share_ctrl_pkg::*;
#(
   parameter int unsigned DATAWIDTH = MIPS_DATAWIDTH
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [5:0]           alucont,
   output logic [DATAWIDTH-1:0] result,
   output logic                 overflow
);
   localparam int unsigned MSB = DATAWIDTH - 1;

   logic [DATAWIDTH-1:0] w_sum;
   logic [DATAWIDTH-1:0] w_diff;

   assign w_sum  = a + b;
   assign w_diff = a - b;

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alucont)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_NOR: result = ~(a | b);
         ALU_ADD: begin
            result   = w_sum;
            overflow = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
         end
         ALU_SUB: begin
            result   = w_diff;
            overflow = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
         end
         ALU_SLT: result = {{(DATAWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_LUI: result = DATAWIDTH'({b[15:0], 16'h0000});
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/alu_share_ctrl_rr_pick.sv
// Round-robin picker: one-hot grant to the first set request strictly
// after the pointer, wrapping; zero when nothing is requested.
module alu_rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant
);
   logic          w_found;
   logic [PW-1:0] w_idx;

   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         w_idx = PW'((32'(i_ptr) + k) % NREQ);
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one alu among NREQ requesters: round-robin capture,
// one execute cycle from registered operands, result held until accepted.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned DATAWIDTH = MIPS_DATAWIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   alu_share_ctrl_if.slave      bus,
   output logic                 busy
);
   localparam int unsigned PW = $clog2(NREQ);

   aluctl_state_t        r_state, w_next;
   logic [DATAWIDTH-1:0] r_a, r_b, r_result;
   logic [5:0]           r_alucont;
   logic [PW-1:0]        r_owner, r_ptr, w_gid;
   logic                 r_ovf, r_err;
   logic [NREQ-1:0]      w_grant;
   logic [DATAWIDTH-1:0] w_alu_result;
   logic                 w_alu_ovf, w_code_ok, w_is_arith, w_accept;

   alu_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .i_req   (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
      .a        (r_a),
      .b        (r_b),
      .alucont  (r_alucont),
      .result   (w_alu_result),
      .overflow (w_alu_ovf)
   );

   always_comb begin
      w_gid = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (w_grant[k]) w_gid = PW'(k);
      end
   end

   assign w_code_ok  = alucont_valid(r_alucont);
   assign w_is_arith = (r_alucont == ALU_ADD) || (r_alucont == ALU_SUB);
   assign w_accept   = bus.resp_ready[r_owner];

   // Gated by reset_n so no grant is visible while reset is held.
   assign bus.req_ready = (r_state == IDLE && reset_n) ? w_grant : '0;

   always_comb begin
      bus.resp_valid          = '0;
      bus.resp_valid[r_owner] = (r_state == RESP);
   end

   assign bus.resp_result   = r_result;
   assign bus.resp_overflow = r_ovf;
   assign bus.resp_err      = r_err;
   assign busy              = (r_state != IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (|w_grant) w_next = EXEC;
         EXEC:    w_next = RESP;
         RESP:    if (w_accept) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_alucont <= '0;
         r_owner   <= '0;
         r_ptr     <= PW'(NREQ - 1);
         r_result  <= '0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (r_state == IDLE && |w_grant) begin
            r_a       <= bus.req_a[w_gid];
            r_b       <= bus.req_b[w_gid];
            r_alucont <= bus.req_alucont[w_gid];
            r_owner   <= w_gid;
            r_ptr     <= w_gid;
         end
         if (r_state == EXEC) begin
            r_result <= w_code_ok ? w_alu_result : '0;
            r_ovf    <= w_code_ok && w_is_arith && w_alu_ovf;
            r_err    <= !w_code_ok;
         end
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: arithmetic results, round-robin order,
// response back-pressure, invalid codes and reset abort.
module tb_alu_share_ctrl;
   import alu_share_ctrl_pkg::*;

   localparam int unsigned NREQ = 2;
   localparam int unsigned DW   = 32;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        busy;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   alu_share_ctrl_if #(.NREQ(NREQ), .DATAWIDTH(DW)) bus ();

   alu_share_ctrl #(.NREQ(NREQ), .DATAWIDTH(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One isolated operation from requester id with resp_ready held high.
   task automatic do_op(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] code, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_err);
      logic [1:0] m;
      m = 2'(1 << id);
      @(negedge clk);
      bus.req_valid       = m;
      bus.req_a[id]       = a;
      bus.req_b[id]       = b;
      bus.req_alucont[id] = code;
      bus.resp_ready      = '1;
      #1 check("op_req_ready", 64'(bus.req_ready), 64'(m));
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      check("op_exec_busy", 64'(busy), 64'd1);
      check("op_exec_no_resp", 64'(bus.resp_valid), 64'd0);
      @(negedge clk);
      #1;
      check("op_resp_valid", 64'(bus.resp_valid), 64'(m));
      check("op_result", 64'(bus.resp_result), 64'(exp_res));
      check("op_overflow", 64'(bus.resp_overflow), 64'(exp_ovf));
      check("op_err", 64'(bus.resp_err), 64'(exp_err));
      @(negedge clk);
      #1;
      check("op_done_valid", 64'(bus.resp_valid), 64'd0);
      check("op_done_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      bus.req_valid   = '0;
      bus.req_a       = '0;
      bus.req_b       = '0;
      bus.req_alucont = '0;
      bus.resp_ready  = '0;

      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_result", 64'(bus.resp_result), 64'd0);
      check("rst_ovf_err", 64'({bus.resp_overflow, bus.resp_err}), 64'd0);
      bus.req_valid = 2'b01;
      #1 check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      bus.req_valid = '0;
      @(negedge clk);
      reset_n = 1'b1;

      do_op(0, 32'd5, 32'd7, ALU_ADD, 32'h0000000C, 1'b0, 1'b0);
      do_op(1, 32'h7FFFFFFF, 32'hFFFFFFFF, ALU_SUB, 32'h80000000, 1'b1, 1'b0);
      do_op(1, 32'hFFFFFFFD, 32'd2, ALU_SLT, 32'd1, 1'b0, 1'b0);

      // Both requesting continuously: grants alternate starting with 0.
      @(negedge clk);
      for (int unsigned i = 0; i < NREQ; i++) begin
         bus.req_a[i]       = 32'hF0F0F0F0;
         bus.req_b[i]       = 32'hFF00FF00;
         bus.req_alucont[i] = ALU_AND;
      end
      bus.req_valid  = 2'b11;
      bus.resp_ready = 2'b11;
      for (int unsigned k = 0; k < 4; k++) begin
         logic [1:0] g;
         g = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1 check("rr_grant", 64'(bus.req_ready), 64'(g));
         @(negedge clk);
         @(negedge clk);
         #1;
         check("rr_resp_valid", 64'(bus.resp_valid), 64'(g));
         check("rr_result", 64'(bus.resp_result), 64'hF000F000);
         @(negedge clk);
      end
      bus.req_valid = '0;

      // Owner 0 stalls its response while requester 1 waits.
      @(negedge clk);
      bus.req_b[0]       = 32'h00001234;
      bus.req_alucont[0] = ALU_LUI;
      bus.req_valid      = 2'b01;
      bus.resp_ready     = 2'b00;
      #1 check("stall_grant0", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      bus.req_a[1]       = 32'd3;
      bus.req_b[1]       = 32'd4;
      bus.req_alucont[1] = ALU_ADD;
      bus.req_valid      = 2'b10;
      bus.resp_ready     = 2'b10;
      for (int unsigned k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check("stall_resp_valid", 64'(bus.resp_valid), 64'd1);
         check("stall_result", 64'(bus.resp_result), 64'h12340000);
         check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.resp_ready = 2'b01;
      @(negedge clk);
      #1;
      check("after_accept_grant1", 64'(bus.req_ready), 64'd2);
      check("after_accept_valid", 64'(bus.resp_valid), 64'd0);
      @(negedge clk);
      bus.req_valid  = '0;
      bus.resp_ready = 2'b11;
      @(negedge clk);
      #1;
      check("req1_resp_valid", 64'(bus.resp_valid), 64'd2);
      check("req1_result", 64'(bus.resp_result), 64'd7);
      @(negedge clk);

      do_op(0, 32'd1, 32'd1, 6'b111111, 32'd0, 1'b0, 1'b1);
      do_op(0, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0, 1'b0);

      // Reset during EXEC aborts the operation and restores the pointer.
      @(negedge clk);
      bus.req_a[0]       = 32'd5;
      bus.req_b[0]       = 32'd7;
      bus.req_alucont[0] = ALU_ADD;
      bus.req_valid      = 2'b01;
      bus.resp_ready     = 2'b11;
      @(negedge clk);
      bus.req_valid = '0;
      #1 check("abort_busy_before", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("abort_result", 64'(bus.resp_result), 64'd0);
      check("abort_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 check("abort_no_resp", 64'(bus.resp_valid), 64'd0);
      end
      bus.req_valid = 2'b11;
      #1 check("post_reset_grant", 64'(bus.req_ready), 64'd1);
      bus.req_valid = '0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences and time-shares the single combinational alu datapath (a, b, alucont → result, overflow) between NREQ requesters, e.g. the execute stage and an address/branch-compare unit.
- Captures one request, drives the alu from registered operands, and registers the result.
- Holds the result until the owning requester accepts it.
- Grants round-robin and flags alucont codes the alu does not implement.

Parameters:
- DATAWIDTH, 32 (from mipspkg): operand/result width.
- NREQ, 2: number of requesters, 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request strobe.
- req_ready  out  NREQ  one-hot grant; a request is accepted when req_valid[i] && req_ready[i].
- req_a  in  NREQ x DATAWIDTH  operand A per requester.
- req_b  in  NREQ x DATAWIDTH  operand B per requester.
- req_alucont  in  NREQ x 6  alu control per requester.
- resp_valid  out  NREQ  one-hot; result is available for requester i.
- resp_ready  in  NREQ  per-requester response accept.
- resp_result  out  DATAWIDTH  shared result bus; meaningful only while any resp_valid is high.
- resp_overflow  out  1  signed overflow; valid for ADD/SUB only, else 0.
- resp_err  out  1  1 when the captured alucont is not a supported code.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n low): state=IDLE; req_ready=0, resp_valid=0, resp_result=0, resp_overflow=0, resp_err=0, busy=0; rr pointer=NREQ-1, so requester 0 wins first.
- Supported alucont codes: AND 000000, OR 000001, ADD 000010, SUB 100010, SLT 000011, XOR 000100, NOR 000101, LUI 000110. All others are invalid.
- FSM IDLE → EXEC → RESP → IDLE.
- IDLE:
  - req_ready = rr_pick(req_valid): the first valid requester after the rr pointer, wrapping.
  - req_ready is combinational from req_valid, and is 0 when no request is valid.
  - On handshake: capture a, b, alucont and the owner id into registers; rr pointer=id; go to EXEC.
- EXEC:
  - The alu is driven only from the captured registers.
  - At the clock edge: resp_result=alu result; resp_overflow=alu overflow if alucont is ADD/SUB, else 0; resp_err=invalid(alucont).
  - If invalid, resp_result=0 and resp_overflow=0.
  - Go to RESP.
- RESP:
  - resp_valid[owner]=1.
  - resp_result, resp_overflow and resp_err are held stable until resp_ready[owner]=1.
  - On accept (same edge): resp_valid→0, go to IDLE.
  - resp_ready of non-owners is ignored.
- Latency: handshake in cycle N gives resp_valid from cycle N+2. Peak throughput is one op per 3 cycles.
- req_ready is 0 outside IDLE, so requests arriving in EXEC/RESP wait with valid held. Requesters must hold req_* stable while valid && !ready.
- Simultaneous requests: round-robin. With both requesting continuously the grant order is 0,1,0,1…; a lone requester is granted every time.
- An owner dropping resp_ready indefinitely stalls the block; there is no timeout.
- Reset mid-EXEC or mid-RESP aborts the operation with no response issued. The first grant after reset goes to requester 0.
- Arithmetic: operands and result are DATAWIDTH bits; SLT is signed; LUI = b[15:0]<<16; ADD/SUB wrap modulo 2^DATAWIDTH.

Decomposition:
- mipspkg gains:
  - alucont constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR, ALU_NOR, ALU_LUI;
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} aluctl_state_t;
  - function alucont_valid(logic [5:0]).
- One sub-module: alu_rr_pick (NREQ-bit request vector + pointer → one-hot grant), combinational.
- The existing alu is instantiated unchanged.

Test Plan:
- Req0 ADD a=5 b=7, resp_ready=1 → req_ready[0] same cycle; resp_valid[0] two cycles later; result=0x0000000C, overflow=0, err=0.
- Req1 SUB a=0x7FFFFFFF b=0xFFFFFFFF → result=0x80000000, overflow=1. Then SLT a=-3 b=2 → result=1, overflow=0.
- Both requesters valid continuously with AND a=0xF0F0F0F0 b=0xFF00FF00 → grants alternate 0,1,0,1; each result=0xF000F000.
- Req0 LUI b=0x00001234 with resp_ready[0] low 4 cycles while req1 valid → resp_valid[0], result=0x12340000 held stable; req_ready all 0 until accept; req1 granted the cycle after accept.
- Req0 alucont=111111 a=1 b=1 → resp_err=1, result=0, overflow=0; next request ADD 1+1 → err=0, result=2.
- Assert reset_n low during EXEC → all outputs 0 immediately; no resp_valid afterwards. With both requesting after release, requester 0 is granted first.
